// File: rtl/mram_access_arbiter.sv
// mram_access_arbiter: round-robin arbiter for two requesters sharing one MRAM port
// Runs each granted command through SETUP, ACCESS and HOLD phases and drives the
// active-low MRAM strobes from registers. Read data is captured at the end of ACCESS.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req/we/be/addr/wdata 0 and 1  requester commands (req held until gnt)
//   gnt0/gnt1, done0/done1        single-cycle accept / completion pulses
//   rdata, busy                   captured read data, non-idle flag
//   mram_addr, mram_dq_out/in     MRAM address and data
//   chip_en, write_en, out_en     E, W, G strobes (active low)
//   lower_byte_en, upper_byte_en  LB, UB byte strobes (active low)
module mram_access_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int T_SETUP  = 1,
    parameter int T_ACCESS = 3,
    parameter int T_HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mram_addr,
    output logic [DATA_W-1:0] mram_dq_out,
    input  logic [DATA_W-1:0] mram_dq_in,
    output logic              chip_en,
    output logic              write_en,
    output logic              out_en,
    output logic              lower_byte_en,
    output logic              upper_byte_en
);
    localparam int T_MAX = (T_SETUP > T_ACCESS) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                                : ((T_ACCESS > T_HOLD) ? T_ACCESS : T_HOLD);
    localparam int CW = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              last, last_n, owner, owner_n, wr, wr_n, win;
    logic              gnt0_n, gnt1_n, done0_n, done1_n;
    logic              ce_n, we_n, oe_n, lb_n, ub_n;
    logic [DATA_W-1:0] rdata_n, dq_n;
    logic [ADDR_W-1:0] addr_n;

    // cnt holds the cycles left in the current phase; each transition reloads it
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE) ? cnt : cnt - CW'(1);
        last_n  = last;
        owner_n = owner;
        wr_n    = wr;
        win     = 1'b0;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        done0_n = 1'b0;
        done1_n = 1'b0;
        ce_n    = chip_en;
        we_n    = write_en;
        oe_n    = out_en;
        lb_n    = lower_byte_en;
        ub_n    = upper_byte_en;
        rdata_n = rdata;
        addr_n  = mram_addr;
        dq_n    = mram_dq_out;
        case (state)
            IDLE: if (req0 | req1) begin
                // on a tie the requester not granted last time wins
                win     = (req0 & req1) ? ~last : req1;
                state_n = SETUP;
                cnt_n   = CW'(T_SETUP - 1);
                last_n  = win;
                owner_n = win;
                wr_n    = win ? we1 : we0;
                addr_n  = win ? addr1 : addr0;
                dq_n    = win ? wdata1 : wdata0;
                lb_n    = ~(win ? be1[0] : be0[0]);
                ub_n    = ~(win ? be1[1] : be0[1]);
                gnt0_n  = ~win;
                gnt1_n  = win;
                ce_n    = 1'b0;
            end
            SETUP: if (cnt == '0) begin
                state_n = ACCESS;
                cnt_n   = CW'(T_ACCESS - 1);
                we_n    = ~wr;
                oe_n    = wr;
            end
            ACCESS: if (cnt == '0) begin
                state_n = HOLD;
                cnt_n   = CW'(T_HOLD - 1);
                we_n    = 1'b1;
                oe_n    = 1'b1;
                // a read with no byte enabled transfers nothing, so rdata is kept
                if (!wr && !(lower_byte_en && upper_byte_en))
                    rdata_n = mram_dq_in;
            end
            HOLD: if (cnt == '0) begin
                state_n = IDLE;
                ce_n    = 1'b1;
                lb_n    = 1'b1;
                ub_n    = 1'b1;
                done0_n = ~owner;
                done1_n = owner;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last          <= 1'b1;
            owner         <= 1'b0;
            wr            <= 1'b0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            busy          <= 1'b0;
            rdata         <= '0;
            mram_addr     <= '0;
            mram_dq_out   <= '0;
            chip_en       <= 1'b1;
            write_en      <= 1'b1;
            out_en        <= 1'b1;
            lower_byte_en <= 1'b1;
            upper_byte_en <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            last          <= last_n;
            owner         <= owner_n;
            wr            <= wr_n;
            gnt0          <= gnt0_n;
            gnt1          <= gnt1_n;
            done0         <= done0_n;
            done1         <= done1_n;
            busy          <= (state_n != IDLE);
            rdata         <= rdata_n;
            mram_addr     <= addr_n;
            mram_dq_out   <= dq_n;
            chip_en       <= ce_n;
            write_en      <= we_n;
            out_en        <= oe_n;
            lower_byte_en <= lb_n;
            upper_byte_en <= ub_n;
        end
    end
endmodule
